uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that consumes the TX_OUT line of the UART transmitter and rebuilds parallel bytes. The frame format is the transmitter's: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1), line idle-high. A bit-cell timer samples each bit at mid-cell. The block reports good bytes, parity errors and stop (framing) errors as one-cycle pulses.

Parameters:
PRESCALE, 1, clocks per bit cell. Must be >=1. The default of 1 matches the transmitter's one-bit-per-clock timing.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
RX_IN  input  1  serial line, idle high, same clock domain as clk
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = odd parity (bit = ~^data), 1 = even parity (bit = ^data)
P_DATA  output  8  last correctly received byte
DATA_VALID  output  1  one-cycle pulse: P_DATA updated with a good frame
PAR_ERR  output  1  one-cycle pulse: received parity bit mismatched
STP_ERR  output  1  one-cycle pulse: stop bit sampled as 0
Busy  output  1  high while a frame is being received

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-frame):
  - state=IDLE, all counters 0.
  - P_DATA=8'h00, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, Busy=0.
  - No pulse is emitted for an aborted frame.
- Bit cell: PRESCALE cycles, index k=0..PRESCALE-1. Sample point is k=MID=PRESCALE/2 (integer division). Cell end is k=PRESCALE-1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Busy=0.
  - On RX_IN==0, that cycle is start-cell k=0. On that edge:
    - Latch PAR_EN and PAR_TYP; mid-frame changes are ignored.
    - Set Busy=1.
    - If PRESCALE==1, go to DATA (start bit accepted). Otherwise go to START with k=1.
- START: at k=MID, if RX_IN==1 it is a false start: go to IDLE, Busy=0, no pulses. Otherwise go to DATA at cell end.
- DATA:
  - At each k=MID, shift RX_IN into bit index bit_cnt (LSB first).
  - After bit 7's cell end, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY:
  - At k=MID, compute par_bad = (RX_IN != expected). Expected is ~^shift for PAR_TYP=0 and ^shift for PAR_TYP=1.
  - Go to STOP at cell end.
- STOP: at k=MID (the stop-sample edge), go straight to IDLE without waiting for cell end, and set Busy=0. Also on that edge:
  - STP_ERR = (RX_IN==0).
  - PAR_ERR = par_bad && PAR_EN(latched).
  - If neither error: P_DATA <= shift and DATA_VALID=1. Otherwise P_DATA holds its old value and DATA_VALID=0.
  - PAR_ERR and STP_ERR may both pulse in the same cycle.
- Pulses last exactly one cycle. They are deasserted on the next edge unless the next frame produces another.
- Latency: pulses are visible in the cycle after the stop-sample edge. With PRESCALE=1, DATA_VALID is high the cycle after the stop bit is on RX_IN.
- Back-to-back frames: zero idle cycles are tolerated. In IDLE, RX_IN==0 is accepted on the cycle right after the stop sample.
- par_bad is cleared at start detection.

Decomposition:
- Shared package uart_pkg:
  - State enum IDLE/START/DATA/PARITY/STOP, common with the transmitter.
  - PAR_ODD=0 and PAR_EVEN=1 constants.
  - DATA_W=8.
- One sub-module, uart_rx_bit_timer:
  - Parameter PRESCALE; inputs clk, reset, restart.
  - Outputs sample_stb (k==MID) and end_stb (k==PRESCALE-1).
  - Counter width max(1,$clog2(PRESCALE)).
  - Restart forces k=1 (or k=0 when PRESCALE==1).

Test Plan:
- Loopback, PRESCALE=1, transmitter drives RX_IN; 8'hA5, PAR_EN=1, PAR_TYP=1 (parity bit 0) -> DATA_VALID pulse, P_DATA=8'hA5, PAR_ERR=0, STP_ERR=0.
- Same byte with PAR_TYP=0 (parity bit 1), then 8'h3C with PAR_EN=0 (10-bit frame) -> both received; P_DATA=8'hA5 then 8'h3C; Busy high exactly over each frame.
- Directed line: 8'hA5 even parity with the parity bit forced to 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA keeps previous 8'h3C.
- Directed line: 8'h00, no parity, stop bit 0 -> STP_ERR pulse, DATA_VALID=0. A following 8'hFF frame with zero gap -> P_DATA=8'hFF.
- PRESCALE=4: RX_IN low 2 cycles then high -> back to IDLE at k=2, no pulses. Then a full 8'h81 frame at 4 clocks/bit -> DATA_VALID, P_DATA=8'h81.
- Assert reset during DATA bit 4 of 8'h55 -> next cycle all outputs 0, state IDLE, no pulse. A fresh frame 8'h55 then receives correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity polarity constants
// and the parity-bit helper used by both transmitter and receiver.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Value the parity bit must carry for the given data byte and parity type.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                      input logic              par_typ);
    return (par_typ == PAR_EVEN) ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-cell timer: counts k = 0..PRESCALE-1 per cell and flags the mid-cell
// sample point and the cell end. Restart marks the start-detect cycle as k=0.
module uart_rx_bit_timer #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic sample_stb,
  output logic end_stb
);

  localparam int            CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] MID       = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] LAST      = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] RESTART_K = (PRESCALE == 1) ? '0 : CW'(1);

  logic [CW-1:0] k_q, k_d;

  // The restart cycle itself is k=0, so the counter resumes at k=1.
  always_comb begin
    k_d = k_q;
    if (restart)          k_d = RESTART_K;
    else if (k_q == LAST) k_d = '0;
    else                  k_d = k_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) k_q <= '0;
    else       k_q <= k_d;
  end

  assign sample_stb = (k_q == MID);
  assign end_stb    = (k_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing sampled at mid-cell, with
// one-cycle pulses for a good byte, a parity error and a stop (framing) error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_VALID,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              Busy
);

  localparam int BCW = $clog2(DATA_W);

  uart_state_e       state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_bad_q, par_bad_d;
  logic              dv_q, dv_d;
  logic              pe_q, pe_d;
  logic              se_q, se_d;
  logic              restart, sample_stb, end_stb, frame_err;

  uart_rx_bit_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .sample_stb (sample_stb),
    .end_stb    (end_stb)
  );

  assign frame_err = !RX_IN || (par_bad_q && par_en_q);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    restart   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          restart   = 1'b1;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = (PRESCALE == 1) ? DATA : START;
        end
      end
      START: begin
        if (sample_stb && RX_IN) state_d = IDLE;
        else if (end_stb)        state_d = DATA;
      end
      DATA: begin
        if (sample_stb) shift_d[bit_cnt_q] = RX_IN;
        if (end_stb) begin
          if (bit_cnt_q == BCW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample_stb) par_bad_d = (RX_IN != parity_bit(shift_q, par_typ_q));
        if (end_stb)    state_d   = STOP;
      end
      STOP: begin
        // Leave at the stop sample so a back-to-back start is seen next cycle.
        if (sample_stb) begin
          state_d = IDLE;
          se_d    = !RX_IN;
          pe_d    = par_bad_q && par_en_q;
          if (!frame_err) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: two receivers (1 and 4 clocks per bit) fed
// by a bit-level line driver, checked against a frame-level outcome model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx1 = 1'b1, rx4 = 1'b1;
  logic       par_en = 1'b0, par_typ = 1'b0;
  logic [7:0] pd1, pd4;
  logic       dv1, dv4, pe1, pe4, se1, se4, busy1, busy4;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_pdata [2];
  logic       busy_ok, quiet;

  always #5 clk = ~clk;

  uart_rx #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .RX_IN(rx1), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .P_DATA(pd1), .DATA_VALID(dv1), .PAR_ERR(pe1), .STP_ERR(se1), .Busy(busy1)
  );

  uart_rx #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .RX_IN(rx4), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .P_DATA(pd4), .DATA_VALID(dv4), .PAR_ERR(pe4), .STP_ERR(se4), .Busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {Busy, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}
  function automatic logic [11:0] outs(input int p);
    return (p == 1) ? {busy1, dv1, pe1, se1, pd1} : {busy4, dv4, pe4, se4, pd4};
  endfunction

  task automatic set_rx(input int p, input logic v);
    if (p == 1) rx1 = v;
    else        rx4 = v;
  endtask

  // One in-frame clock: the receiver must stay busy and raise no pulse.
  task automatic frame_cycle(input int p, input logic v);
    logic [11:0] o;
    set_rx(p, v);
    tick();
    o       = outs(p);
    busy_ok = busy_ok & o[11];
    quiet   = quiet & (o[10:8] == 3'b000);
  endtask

  task automatic send_frame(input int p, input logic [7:0] b, input logic pen,
                            input logic ptyp, input logic flip, input logic stop_v,
                            input int gap);
    int          idx;
    int          mid;
    logic        pbit, exp_pe, exp_se, exp_dv;
    logic [11:0] o;
    idx = (p == 1) ? 0 : 1;
    mid = p / 2;
    // Frame-level model of the expected outcome.
    pbit   = (ptyp ? ^b : ~^b) ^ flip;
    exp_pe = pen && flip;
    exp_se = !stop_v;
    exp_dv = !exp_pe && !exp_se;

    check("busy_idle", {31'b0, outs(p)[11]}, 32'd0);
    par_en  = pen;
    par_typ = ptyp;
    set_rx(p, 1'b0);
    tick();
    o = outs(p);
    check("busy_rise", {31'b0, o[11]}, 32'd1);
    check("pulse_clear", {29'b0, o[10:8]}, 32'd0);
    // Configuration changes after the start edge must be ignored.
    par_en  = 1'($urandom);
    par_typ = 1'($urandom);
    busy_ok = 1'b1;
    quiet   = 1'b1;
    for (int k = 1; k < p; k++) frame_cycle(p, 1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < p; k++) frame_cycle(p, b[i]);
    if (pen)
      for (int k = 0; k < p; k++) frame_cycle(p, pbit);
    for (int k = 0; k < mid; k++) frame_cycle(p, stop_v);
    check("busy_hold", {31'b0, busy_ok}, 32'd1);
    check("no_early_pulse", {31'b0, quiet}, 32'd1);

    set_rx(p, stop_v);
    tick();
    if (exp_dv) exp_pdata[idx] = b;
    o = outs(p);
    check("data_valid", {31'b0, o[10]}, {31'b0, exp_dv});
    check("par_err",    {31'b0, o[9]},  {31'b0, exp_pe});
    check("stp_err",    {31'b0, o[8]},  {31'b0, exp_se});
    check("p_data",     {24'b0, o[7:0]}, {24'b0, exp_pdata[idx]});
    check("busy_fall",  {31'b0, o[11]}, 32'd0);

    set_rx(p, 1'b1);
    for (int k = mid + 1; k < p; k++) tick();
    for (int k = 0; k < gap * p; k++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    exp_pdata[0] = 8'h00;
    exp_pdata[1] = 8'h00;
    repeat (3) tick();
    check("reset_p1", {20'b0, outs(1)}, 32'd0);
    check("reset_p4", {20'b0, outs(4)}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed frames at one clock per bit.
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    send_frame(1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2);

    // False start at four clocks per bit: low for k=0,1 then high at the sample.
    check("fs_idle", {31'b0, busy4}, 32'd0);
    rx4 = 1'b0;
    tick();
    check("fs_busy", {31'b0, busy4}, 32'd1);
    tick();
    rx4 = 1'b1;
    tick();
    check("fs_abort", {20'b0, outs(4)}, 32'd0);
    repeat (6) tick();
    check("fs_quiet", {20'b0, outs(4)}, 32'd0);
    send_frame(4, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1);

    // Reset asserted while data bit 4 of 8'h55 is on the line.
    par_en = 1'b0;
    rx1 = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rx1 = 1'(8'h55 >> i);
      tick();
    end
    rx1   = 1'(8'h55 >> 4);
    reset = 1'b1;
    tick();
    exp_pdata[0] = 8'h00;
    exp_pdata[1] = 8'h00;
    check("midreset_p1", {20'b0, outs(1)}, 32'd0);
    check("midreset_p4", {20'b0, outs(4)}, 32'd0);
    reset = 1'b0;
    rx1   = 1'b1;
    repeat (3) tick();
    check("midreset_quiet", {20'b0, outs(1)}, 32'd0);
    send_frame(1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1);

    // Randomized frames on both receivers, with occasional corrupted bits.
    for (int n = 0; n < 60; n++) begin
      send_frame(($urandom_range(1, 0) == 1) ? 1 : 4,
                 8'($urandom),
                 1'($urandom),
                 1'($urandom),
                 ($urandom_range(7, 0) == 0),
                 ($urandom_range(7, 0) != 0),
                 int'($urandom_range(2, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
